// File: rtl/cwd_pkg.sv
// Shared definitions for the codeword deserializer: default width, FSM states
// and the aborted-frame counter width.
package cwd_pkg;

    localparam int CODE_LEN_DEF = 8;
    localparam int ABORT_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } cwd_state_e;

    // Saturating increment; the counter sticks at its maximum value.
    function automatic logic [ABORT_CNT_W-1:0] sat_inc(input logic [ABORT_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cwd_hold_reg.sv
// Valid/ready holding register between the shift register and the multiplier.
// empty_or_drain tells the FSM a new word can be loaded this cycle.
module cwd_hold_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         drain_ready,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         empty_or_drain
);

    // Handshake: a word is consumed on any cycle where valid && drain_ready.
    // valid and data hold steady while valid && !drain_ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (valid && drain_ready) begin
            valid <= 1'b0;
        end
    end

    assign empty_or_drain = !valid || drain_ready;

endmodule

// File: rtl/cw_deserializer.sv
// Serial-to-parallel codeword assembler feeding the GF(2) parity-check multiplier.
// Optional macro CWD_ABORT_CNT_EN adds the saturating abort_cnt output.
module cw_deserializer
    import cwd_pkg::*;
#(
    parameter int CODE_LEN = CODE_LEN_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sof,
    input  logic                   bit_in,
    input  logic                   bit_valid,
    output logic                   bit_ready,
    output logic [CODE_LEN-1:0]    cw_out,
    output logic                   cw_valid,
    input  logic                   cw_ready,
    output logic                   busy,
`ifdef CWD_ABORT_CNT_EN
    output logic [ABORT_CNT_W-1:0] abort_cnt,
`endif
    output cwd_state_e             dbg_state
);

    localparam int               CNT_W    = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CODE_LEN - 1);

    cwd_state_e          state;
    logic [CNT_W-1:0]    cnt;
    logic [CODE_LEN-1:0] sr;
    logic [CODE_LEN-1:0] next_word;
    logic                accept;
    logic                abort_evt;
    logic                word_done;
    logic                hold_load;
    logic [CODE_LEN-1:0] hold_data;
    logic                hold_empty_or_drain;

    assign bit_ready = (state != FULL);
    assign busy      = (state != IDLE);
    assign dbg_state = state;
    assign accept    = bit_valid && bit_ready;

    always_comb begin
        next_word      = sr;
        next_word[cnt] = bit_in;
        abort_evt      = accept && sof && (state == COLLECT);
        word_done      = accept && !sof && (state == COLLECT) && (cnt == LAST_IDX);
        // In FULL the finished word waits in sr until the held word drains.
        hold_load      = (word_done && hold_empty_or_drain) || ((state == FULL) && cw_ready);
        hold_data      = (state == FULL) ? sr : next_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && sof) begin
                        sr    <= CODE_LEN'(bit_in);
                        cnt   <= CNT_W'(1);
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        if (sof) begin
                            // Restart framing: this bit is bit 0 of the new word.
                            sr  <= CODE_LEN'(bit_in);
                            cnt <= CNT_W'(1);
                        end else if (cnt == LAST_IDX) begin
                            sr    <= next_word;
                            cnt   <= '0;
                            state <= hold_empty_or_drain ? IDLE : FULL;
                        end else begin
                            sr  <= next_word;
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (cw_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    cwd_hold_reg #(
        .W(CODE_LEN)
    ) u_hold (
        .clk            (clk),
        .rst            (rst),
        .load           (hold_load),
        .load_data      (hold_data),
        .drain_ready    (cw_ready),
        .data           (cw_out),
        .valid          (cw_valid),
        .empty_or_drain (hold_empty_or_drain)
    );

`ifdef CWD_ABORT_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            abort_cnt <= '0;
        end else if (abort_evt) begin
            abort_cnt <= sat_inc(abort_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_cw_deserializer.sv
// Directed bench for cw_deserializer (CODE_LEN=8): framing, backpressure, abort,
// unframed bits, reset mid-word and simultaneous drain/complete.
module tb_cw_deserializer;
    import cwd_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         sof;
    logic         bit_in;
    logic         bit_valid;
    logic         bit_ready;
    logic [W-1:0] cw_out;
    logic         cw_valid;
    logic         cw_ready;
    logic         busy;
    cwd_state_e   dbg_state;
`ifdef CWD_ABORT_CNT_EN
    logic [ABORT_CNT_W-1:0] abort_cnt;
`endif

    int checks    = 0;
    int errors    = 0;
    int words_rcv = 0;
    logic [W-1:0] exp_q[$];

    cw_deserializer #(.CODE_LEN(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .sof       (sof),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .cw_out    (cw_out),
        .cw_valid  (cw_valid),
        .cw_ready  (cw_ready),
        .busy      (busy),
`ifdef CWD_ABORT_CNT_EN
        .abort_cnt (abort_cnt),
`endif
        .dbg_state (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: a word is consumed at the next rising edge if valid && ready mid-cycle.
    always @(negedge clk) begin
        if (rst === 1'b1 && cw_valid === 1'b1 && cw_ready === 1'b1) begin
            words_rcv++;
            if (exp_q.size() == 0) begin
                check("unexpected_word", {24'h0, cw_out}, 32'hFFFF_FFFF);
            end else begin
                check("sb_word", {24'h0, cw_out}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b, input logic s);
        bit_valid = 1'b1;
        bit_in    = b;
        sof       = s;
        tick();
    endtask

    task automatic idle();
        bit_valid = 1'b0;
        sof       = 1'b0;
        bit_in    = 1'b0;
        tick();
    endtask

    task automatic send_range(input logic [W-1:0] w, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            send(w[i], i == 0);
        end
    endtask

    initial begin
        rst       = 1'b0;
        sof       = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        cw_ready  = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_cw_valid", cw_valid, 1'b0);
        check("rst_cw_out", cw_out, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_bit_ready", bit_ready, 1'b1);
        check("rst_state", dbg_state, IDLE);
`ifdef CWD_ABORT_CNT_EN
        check("rst_abort_cnt", abort_cnt, 8'd0);
`endif
        rst = 1'b1;
        tick();

        // Basic word, one-cycle latency, single-cycle valid
        cw_ready = 1'b1;
        exp_q.push_back(8'hB2);
        send_range(8'hB2, 0, 6);
        check("basic_busy_mid", busy, 1'b1);
        check("basic_state_mid", dbg_state, COLLECT);
        check("basic_valid_early", cw_valid, 1'b0);
        send_range(8'hB2, 7, 7);
        bit_valid = 1'b0;
        check("basic_valid", cw_valid, 1'b1);
        check("basic_word", cw_out, 8'hB2);
        check("basic_busy_done", busy, 1'b0);
        idle();
        check("basic_valid_drop", cw_valid, 1'b0);

        // Backpressure: second word parks in the shift register
        cw_ready = 1'b0;
        exp_q.push_back(8'hB2);
        exp_q.push_back(8'h5A);
        send_range(8'hB2, 0, 7);
        check("bp_first_held", cw_out, 8'hB2);
        send_range(8'h5A, 0, 7);
        bit_valid = 1'b0;
        check("bp_bit_ready_low", bit_ready, 1'b0);
        check("bp_state_full", dbg_state, FULL);
        check("bp_busy_full", busy, 1'b1);
        repeat (3) idle();
        check("bp_stable_word", cw_out, 8'hB2);
        check("bp_stable_valid", cw_valid, 1'b1);
        cw_ready = 1'b1;
        tick();
        cw_ready = 1'b0;
        check("bp_next_word", cw_out, 8'h5A);
        check("bp_next_valid", cw_valid, 1'b1);
        check("bp_bit_ready_back", bit_ready, 1'b1);
        cw_ready = 1'b1;
        idle();
        check("bp_drained", cw_valid, 1'b0);

        // Abort: 3 framed bits, then a fresh framed word
        exp_q.push_back(8'h3C);
        send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        send_range(8'h3C, 0, 0);
        check("abort_state", dbg_state, COLLECT);
        check("abort_no_word", cw_valid, 1'b0);
        send_range(8'h3C, 1, 7);
        bit_valid = 1'b0;
        check("abort_word", cw_out, 8'h3C);
        check("abort_valid", cw_valid, 1'b1);
`ifdef CWD_ABORT_CNT_EN
        check("abort_cnt", abort_cnt, 8'd1);
`endif
        idle();

        // Unframed bits are dropped in IDLE
        repeat (5) send(1'b1, 1'b0);
        bit_valid = 1'b0;
        check("unframed_busy", busy, 1'b0);
        check("unframed_valid", cw_valid, 1'b0);
        exp_q.push_back(8'hFF);
        send_range(8'hFF, 0, 7);
        bit_valid = 1'b0;
        check("ff_word", cw_out, 8'hFF);
        check("ff_valid", cw_valid, 1'b1);
        idle();

        // Reset mid-word discards the partial frame
        send_range(8'h0F, 0, 3);
        bit_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_valid", cw_valid, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        check("rstmid_state", dbg_state, IDLE);
        exp_q.push_back(8'h01);
        send_range(8'h01, 0, 6);
        check("rstmid_valid_early", cw_valid, 1'b0);
        send_range(8'h01, 7, 7);
        bit_valid = 1'b0;
        check("rstmid_word", cw_out, 8'h01);
`ifdef CWD_ABORT_CNT_EN
        check("rstmid_abort_cnt", abort_cnt, 8'd0);
`endif
        idle();

        // Drain of the held word coincides with completion of the next
        cw_ready = 1'b0;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'hC3);
        send_range(8'hA5, 0, 7);
        for (int i = 0; i < 7; i++) begin
            send(W'(8'hC3 >> i) & 1'b1, i == 0);
            check("sim_valid_held", cw_valid, 1'b1);
            check("sim_bit_ready", bit_ready, 1'b1);
        end
        cw_ready = 1'b1;
        send(1'b1, 1'b0);
        bit_valid = 1'b0;
        check("sim_word", cw_out, 8'hC3);
        check("sim_valid", cw_valid, 1'b1);
        check("sim_bit_ready_end", bit_ready, 1'b1);
        check("sim_state", dbg_state, IDLE);
        idle();
        check("sim_drained", cw_valid, 1'b0);
        repeat (2) idle();

        // Final report
        check("sb_empty", exp_q.size(), 0);
        check("sb_word_count", words_rcv, 8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
